// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU normaliser.
// Holds default widths, the flag bundle and the exponent ceiling.
package fpu_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 25;

  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
  } fpu_norm_flags_t;

  // All-ones exponent, i.e. the infinity/NaN code.
  function automatic int unsigned exp_max(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter.
// Ports: in (W bits), cnt (zeros above first 1, W if none), all_zero.
module fpu_lzc #(
  parameter int W    = 24,
  localparam int CW  = $clog2(W + 1)
) (
  input  logic [W-1:0]  in,
  output logic [CW-1:0] cnt,
  output logic          all_zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in[i]) cnt = CW'(W - 1 - i);
    end
  end

  assign all_zero = ~|in;

endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage normaliser between mantissa adder and rounder.
// Ports: valid/ready in (in_e_i, in_m_i), valid/ready out
// (out_e_o, out_m_o, zero_o, underflow_o, overflow_o).
module fpu_norm_pipe
  import fpu_pkg::*;
#(
  parameter int  EXP_W = EXP_W_DEF,
  parameter int  MAN_W = MAN_W_DEF,
  localparam int LZC_W = $clog2(MAN_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [EXP_W-1:0] in_e_i,
  input  logic [MAN_W-1:0] in_m_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [EXP_W-1:0] out_e_o,
  output logic [MAN_W-1:0] out_m_o,
  output logic             zero_o,
  output logic             underflow_o,
  output logic             overflow_o
);

  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EMAX = XW'(exp_max(EXP_W));

  logic             s1_v;
  logic             s2_v;
  logic [EXP_W-1:0] s1_e;
  logic [MAN_W-1:0] s1_m;
  logic             s1_c;
  logic             s1_z;
  logic [LZC_W-1:0] s1_lz;
  fpu_norm_flags_t  s2_f;

  logic             s1_en;
  logic             s2_en;
  logic [LZC_W-1:0] lz;
  logic             frac_zero;

  fpu_lzc #(.W(MAN_W - 1)) u_lzc (
    .in       (in_m_i[MAN_W-2:0]),
    .cnt      (lz),
    .all_zero (frac_zero)
  );

  assign s2_en   = !s2_v || ready_i;
  assign s1_en   = !s1_v || s2_en;
  assign ready_o = s1_en;
  assign valid_o = s2_v;

  assign zero_o      = s2_f.zero;
  assign underflow_o = s2_f.underflow;
  assign overflow_o  = s2_f.overflow;

  logic [XW-1:0]    e_x;
  logic [XW-1:0]    e_inc;
  logic [XW-1:0]    lz_x;
  logic [LZC_W-1:0] dn_sh;
  logic [EXP_W-1:0] n_e;
  logic [MAN_W-1:0] n_m;
  fpu_norm_flags_t  n_f;

  always_comb begin
    e_x   = XW'(s1_e);
    e_inc = e_x + XW'(1);
    lz_x  = XW'(s1_lz);
    // Denormal: shift only as far as exponent 1 allows.
    dn_sh = (e_x == '0) ? '0 : LZC_W'(e_x - XW'(1));
    n_e   = s1_e;
    n_m   = s1_m;
    n_f   = '0;
    if (s1_z) begin
      n_e      = '0;
      n_m      = '0;
      n_f.zero = 1'b1;
    end else if (s1_c) begin
      if (e_inc >= EMAX) begin
        n_e          = '1;
        n_m          = '0;
        n_f.overflow = 1'b1;
      end else begin
        n_e = e_inc[EXP_W-1:0];
        // Dropped LSB is folded into sticky.
        n_m = {1'b0, s1_m[MAN_W-1:2], s1_m[1] | s1_m[0]};
      end
    end else if (s1_lz == '0) begin
      n_e = s1_e;
    end else if (e_x > lz_x) begin
      n_e = EXP_W'(e_x - lz_x);
      n_m = s1_m << s1_lz;
    end else begin
      n_e           = '0;
      n_m           = s1_m << dn_sh;
      n_f.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_e    <= '0;
      s1_m    <= '0;
      s1_c    <= 1'b0;
      s1_z    <= 1'b0;
      s1_lz   <= '0;
      out_e_o <= '0;
      out_m_o <= '0;
      s2_f    <= '0;
    end else begin
      if (s1_en) begin
        s1_v <= valid_i;
        if (valid_i) begin
          s1_e  <= in_e_i;
          s1_m  <= in_m_i;
          s1_c  <= in_m_i[MAN_W-1];
          s1_z  <= frac_zero & ~in_m_i[MAN_W-1];
          s1_lz <= lz;
        end
      end
      if (s2_en) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_e_o <= n_e;
          out_m_o <= n_m;
          s2_f    <= n_f;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Directed bench for fpu_norm_pipe with default widths.
// Each scenario task checks its own hand-computed results.
module tb_fpu_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [7:0]  in_e = '0;
  logic [24:0] in_m = '0;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  out_e;
  logic [24:0] out_m;
  logic        zero_o;
  logic        uf_o;
  logic        ovf_o;
  logic [2:0]  flg;

  int n_chk = 0;
  int n_fail = 0;

  assign flg = {zero_o, uf_o, ovf_o};

  fpu_norm_pipe #(.EXP_W(8), .MAN_W(25)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .in_e_i      (in_e),
    .in_m_i      (in_m),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .out_e_o     (out_e),
    .out_m_o     (out_m),
    .zero_o      (zero_o),
    .underflow_o (uf_o),
    .overflow_o  (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(
    input  logic [7:0]  e,
    input  logic [24:0] m,
    output bit          to
  );
    int k;
    valid_i = 1'b1;
    in_e    = e;
    in_m    = m;
    ready_i = 1'b1;
    #1;
    k = 0;
    while (!ready_o && k < 20) begin
      tick();
      k++;
    end
    tick();
    valid_i = 1'b0;
    k = 0;
    while (!valid_o && k < 20) begin
      tick();
      k++;
    end
    to = !valid_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_chk++;
    if (valid_o !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", valid_o);
    if (valid_o !== 1'b0) n_fail++;
    n_chk++;
    if (out_e !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_out_e: got %h want 00", out_e);
    end
    n_chk++;
    if (out_m !== 25'h0) begin
      n_fail++;
      $display("FAIL rst_out_m: got %h want 0", out_m);
    end
    n_chk++;
    if (flg !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 000", flg);
    end
    n_chk++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 1", ready_o);
    end
  endtask

  task automatic test_left_shift();
    ready_i = 1'b1;
    valid_i = 1'b1;
    in_e    = 8'h80;
    in_m    = 25'h0400000;
    tick();
    valid_i = 1'b0;
    n_chk++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: got %b want 0", valid_o);
    end
    tick();
    n_chk++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_2: got %b want 1", valid_o);
    end
    n_chk++;
    if (out_e !== 8'h7F) begin
      n_fail++;
      $display("FAIL ls_e: got %h want 7f", out_e);
    end
    n_chk++;
    if (out_m !== 25'h0800000) begin
      n_fail++;
      $display("FAIL ls_m: got %h want 0800000", out_m);
    end
    n_chk++;
    if (flg !== 3'b000) begin
      n_fail++;
      $display("FAIL ls_flags: got %b want 000", flg);
    end
    tick();
  endtask

  task automatic test_carry();
    bit to;
    beat(8'h80, 25'h1000003, to);
    n_chk++;
    if (to) begin
      n_fail++;
      $display("FAIL cy_timeout: got no valid_o want valid_o");
    end
    n_chk++;
    if (out_e !== 8'h81) begin
      n_fail++;
      $display("FAIL cy_e: got %h want 81", out_e);
    end
    n_chk++;
    if (out_m !== 25'h0800001) begin
      n_fail++;
      $display("FAIL cy_m: got %h want 0800001", out_m);
    end
    n_chk++;
    if (flg !== 3'b000) begin
      n_fail++;
      $display("FAIL cy_flags: got %b want 000", flg);
    end
    tick();
  endtask

  task automatic test_zero_ovf();
    bit to;
    beat(8'h55, 25'h0, to);
    n_chk++;
    if (to || out_e !== 8'h00 || out_m !== 25'h0) begin
      n_fail++;
      $display("FAIL zero_val: got %h/%h want 00/0", out_e, out_m);
    end
    n_chk++;
    if (flg !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_flags: got %b want 100", flg);
    end
    tick();
    beat(8'hFE, 25'h1800000, to);
    n_chk++;
    if (to || out_e !== 8'hFF || out_m !== 25'h0) begin
      n_fail++;
      $display("FAIL ovf_val: got %h/%h want ff/0", out_e, out_m);
    end
    n_chk++;
    if (flg !== 3'b001) begin
      n_fail++;
      $display("FAIL ovf_flags: got %b want 001", flg);
    end
    tick();
  endtask

  task automatic test_underflow();
    bit to;
    beat(8'h03, 25'h0000100, to);
    n_chk++;
    if (to || out_e !== 8'h00 || out_m !== 25'h0000400) begin
      n_fail++;
      $display("FAIL uf3_val: got %h/%h want 00/0000400", out_e, out_m);
    end
    n_chk++;
    if (flg !== 3'b010) begin
      n_fail++;
      $display("FAIL uf3_flags: got %b want 010", flg);
    end
    tick();
    beat(8'h00, 25'h0000100, to);
    n_chk++;
    if (to || out_e !== 8'h00 || out_m !== 25'h0000100) begin
      n_fail++;
      $display("FAIL uf0_val: got %h/%h want 00/0000100", out_e, out_m);
    end
    n_chk++;
    if (flg !== 3'b010) begin
      n_fail++;
      $display("FAIL uf0_flags: got %b want 010", flg);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [7:0]  got[$];
    logic [7:0]  hold_e;
    logic [24:0] hold_m;
    int          idx;
    bit          fi;
    bit          fo;
    idx     = 0;
    hold_e  = '0;
    hold_m  = '0;
    valid_i = 1'b1;
    in_e    = 8'h80;
    in_m    = 25'h0400000;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      ready_i = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
      #1;
      if (c == 2) begin
        hold_e = out_e;
        hold_m = out_m;
        n_chk++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_full: got rdy=%b vld=%b want 0/1", ready_o, valid_o);
        end
        n_chk++;
        if (out_e !== 8'h7F) begin
          n_fail++;
          $display("FAIL bp_head: got %h want 7f", out_e);
        end
      end
      if (c >= 3 && c <= 5) begin
        n_chk++;
        if (out_e !== hold_e || out_m !== hold_m || valid_o !== 1'b1 || ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold: got %h/%h want %h/%h", out_e, out_m, hold_e, hold_m);
        end
      end
      fi = valid_i && ready_o;
      fo = valid_o && ready_i;
      if (fo) got.push_back(out_e);
      tick();
      if (fi) begin
        idx++;
        if (idx == 4) valid_i = 1'b0;
        else in_e = 8'h80 + 8'(idx);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    n_chk++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== 8'h7F + 8'(i)) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 8'h7F + 8'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int         first;
    int         last;
    int         idx;
    bit         fi;
    bit         fo;
    first   = -1;
    last    = -1;
    idx     = 0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    in_e    = 8'h80;
    in_m    = 25'h0400000;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      #1;
      if (valid_i) begin
        n_chk++;
        if (ready_o !== 1'b1) begin
          n_fail++;
          $display("FAIL tp_ready[%0d]: got %b want 1", c, ready_o);
        end
      end
      fi = valid_i && ready_o;
      fo = valid_o && ready_i;
      if (fo) begin
        got.push_back(out_e);
        if (first < 0) first = c;
        last = c;
      end
      tick();
      if (fi) begin
        idx++;
        if (idx == 4) valid_i = 1'b0;
        else in_e = 8'h80 + 8'(idx);
      end
    end
    valid_i = 1'b0;
    n_chk++;
    if (first != 2 || last != 5) begin
      n_fail++;
      $display("FAIL tp_rate: got first=%0d last=%0d want 2/5", first, last);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== 8'h7F + 8'(i)) begin
        n_fail++;
        $display("FAIL tp_order[%0d]: got %h want %h", i, got[i], 8'h7F + 8'(i));
      end
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    ready_i = 1'b0;
    valid_i = 1'b1;
    in_e    = 8'h90;
    in_m    = 25'h0400000;
    tick();
    in_e = 8'h91;
    tick();
    valid_i = 1'b0;
    n_chk++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_full: got vld=%b rdy=%b want 1/0", valid_o, ready_o);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_chk++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_state: got vld=%b rdy=%b want 0/1", valid_o, ready_o);
    end
    n_chk++;
    if (out_e !== 8'h00 || out_m !== 25'h0 || flg !== 3'b000) begin
      n_fail++;
      $display("FAIL mr_out: got %h/%h/%b want 00/0/000", out_e, out_m, flg);
    end
    beat(8'h80, 25'h1000003, to);
    n_chk++;
    if (to || out_e !== 8'h81 || out_m !== 25'h0800001) begin
      n_fail++;
      $display("FAIL mr_fresh: got %h/%h want 81/0800001", out_e, out_m);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_left_shift();
    test_carry();
    test_zero_ovf();
    test_underflow();
    test_back_pressure();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_norm_pipe.md
Name: fpu_norm_pipe

Overview:
- Parametrised, 2-stage pipelined normaliser for the FPU add/sub datapath.
- Sits between the mantissa adder and the rounder.
- Takes a raw exponent/mantissa pair that may have a carry-out or many leading zeros. Returns a normalised pair plus zero, underflow (denormal) and overflow flags.
- Uses a valid/ready handshake with full back-pressure support.
- Replaces the fixed 8/25-bit combinational priority chain with arbitrary widths, right-shift-on-carry, sticky preservation and exponent clamping.

Parameters:
- EXP_W, 8: exponent width.
- MAN_W, 25: mantissa width.
  - Bit MAN_W-1 is the adder carry.
  - Bit MAN_W-2 is the hidden-bit position.
  - Bits below MAN_W-2 are fraction, guard and sticky.
- LZC_W, $clog2(MAN_W), derived: shift-amount width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat this cycle
- in_e_i  in  EXP_W  biased exponent
- in_m_i  in  MAN_W  raw mantissa
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts the output
- out_e_o  out  EXP_W  normalised exponent
- out_m_o  out  MAN_W  normalised mantissa; bit MAN_W-1 is always 0
- zero_o  out  1  result mantissa is zero
- underflow_o  out  1  nonzero result with out_e_o == 0 (denormal)
- overflow_o  out  1  exponent saturated to all-ones; out_m_o == 0 (infinity)

Behaviour:
- Reset (rst_ni == 0 at a clk_i edge):
  - Both stage valid bits clear, so valid_o = 0.
  - out_e_o, out_m_o and all flags register to 0.
  - ready_o = 1 in the cycle after reset.
  - Any in-flight beats are discarded.
- Handshake:
  - A beat transfers in when valid_i && ready_o.
  - A beat transfers out when valid_o && ready_i.
  - ready_o = !s1_v || !s2_v || ready_i.
  - Stage 2 loads when !s2_v || ready_i.
  - Stage 1 loads when it is empty or moving into stage 2.
  - Simultaneous in and out on a full pipe sustains 1 beat/cycle.
  - When valid_o && !ready_i, all outputs hold stable.
- Latency and order:
  - Exactly 2 cycles from input transfer to valid_o with no stall.
  - Beat order is preserved.
- Stage 1 registers the inputs and computes:
  - carry = in_m[MAN_W-1];
  - zero = (in_m == 0);
  - lz = leading-zero count of in_m[MAN_W-2:0], in the range 0..MAN_W-1.
- Stage 2 applies exactly one of the following, in priority order. Arithmetic is in EXP_W+2-bit unsigned, with no wrap.
  1. zero: out_e = 0, out_m = 0, zero_o = 1.
  2. carry:
     - out_m = in_m >> 1, with bit 0 = in_m[1] | in_m[0] (sticky).
     - out_e = in_e + 1.
     - If in_e + 1 >= 2^EXP_W - 1: out_e = all-ones, out_m = 0, overflow_o = 1.
  3. lz == 0 (already normal): pass through unchanged.
  4. in_e > lz: out_e = in_e - lz, out_m = in_m << lz.
  5. Otherwise (denormal):
     - shift = (in_e == 0) ? 0 : in_e - 1;
     - out_m = in_m << shift, out_e = 0, underflow_o = 1.
- Flags are mutually exclusive. A zero input never sets underflow_o.
- Left shifts fill with zeros.
- Only the carry path may lose a bit, and that bit is folded into sticky.

Decomposition:
- fpu_pkg holds:
  - EXP_W/MAN_W defaults;
  - typedef fpu_norm_flags_t as a packed struct {zero, underflow, overflow};
  - function exp_max(EXP_W).
- One sub-module: fpu_lzc, a parametrised combinational leading-zero counter.
  - Ports: in [W-1:0]; cnt [$clog2(W+1)-1:0]; all_zero.
  - Instantiated in stage 1.

Test Plan:
All scenarios use the defaults EXP_W = 8, MAN_W = 25.
1. Left shift: in_e = 0x80, in_m = 0x0400000 -> 2 cycles later out_e = 0x7F, out_m = 0x0800000, all flags 0.
2. Carry with sticky: in_e = 0x80, in_m = 0x1000003 -> out_e = 0x81, out_m = 0x0800001, overflow 0.
3. Zero and overflow:
   - in_e = 0x55, in_m = 0 -> out_e = 0, out_m = 0, zero_o = 1.
   - in_e = 0xFE, in_m = 0x1800000 -> out_e = 0xFF, out_m = 0, overflow_o = 1.
4. Underflow: in_e = 0x03, in_m = 0x0000100 (lz = 15) -> out_e = 0, out_m = 0x0000400, underflow_o = 1. Also in_e = 0x00, in_m = 0x0000100 -> out_m unchanged, underflow_o = 1.
5. Back-pressure: stream 4 beats (scenario 1 values with in_e = 0x80..0x83), ready_i = 0 for cycles 2-5.
   - ready_o drops after 2 beats are held.
   - Outputs hold stable while stalled.
   - On release, out_e = 0x7F..0x82 in order with no loss or duplication.
   - Throughput is 1/cycle with ready_i tied to 1.
6. Reset mid-operation: assert rst_ni = 0 for 1 cycle with both stages valid.
   - Next cycle valid_o = 0, outputs = 0, ready_o = 1.
   - A fresh beat afterwards is processed correctly.
